// File: rtl/mips_decode_pkg.sv
// Shared MIPS decode constants: opcodes, instruction-class encoding and field widths.
package mips_decode_pkg;

    localparam int OPCODE_W = 6;
    localparam int REG_W    = 5;
    localparam int SHAMT_W  = 5;
    localparam int FUNCT_W  = 6;
    localparam int TARGET_W = 28;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
    localparam logic [OPCODE_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OPCODE_W-1:0] OP_XORI  = 6'h0E;
    localparam logic [OPCODE_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OPCODE_W-1:0] OP_COP1  = 6'h11;

    typedef enum logic [1:0] {
        CLASS_R    = 2'd0,
        CLASS_I    = 2'd1,
        CLASS_J    = 2'd2,
        CLASS_COP1 = 2'd3
    } instr_class_t;

    function automatic instr_class_t classify(input logic [OPCODE_W-1:0] opcode);
        case (opcode)
            OP_RTYPE:       return CLASS_R;
            OP_J, OP_JAL:   return CLASS_J;
            OP_COP1:        return CLASS_COP1;
            default:        return CLASS_I;
        endcase
    endfunction

endpackage

// File: rtl/signExtend.sv
// Sign extender: replicates the immediate's top bit up to the output width.
module signExtend #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  immediate,
    output logic [OUT_W-1:0] extended
);

    assign extended = {{(OUT_W-IN_W){immediate[IN_W-1]}}, immediate};

endmodule

// File: rtl/if_id_decode.sv
// IF/ID pipeline stage: two-entry skid buffer (main + skid) with combinational
// field decode of the main entry.
module if_id_decode
    import mips_decode_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORD_W-1:0]   in_instr,
    input  logic [WORD_W-1:0]   in_pc,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORD_W-1:0]   out_pc,
    output logic [OPCODE_W-1:0] out_opcode,
    output logic [REG_W-1:0]    out_rs,
    output logic [REG_W-1:0]    out_rt,
    output logic [REG_W-1:0]    out_rd,
    output logic [SHAMT_W-1:0]  out_shamt,
    output logic [FUNCT_W-1:0]  out_funct,
    output logic [IMM_W-1:0]    out_imm16,
    output logic [WORD_W-1:0]   out_imm_ext,
    output logic [TARGET_W-1:0] out_target,
    output logic [1:0]          out_class
);

    logic              main_valid, main_valid_d;
    logic [WORD_W-1:0] main_instr, main_instr_d;
    logic [WORD_W-1:0] main_pc, main_pc_d;
    logic              skid_valid, skid_valid_d;
    logic [WORD_W-1:0] skid_instr, skid_instr_d;
    logic [WORD_W-1:0] skid_pc, skid_pc_d;
    logic              accept;
    logic [WORD_W-1:0] imm_sext;

    assign accept = in_valid & in_ready & ~flush;

    always_comb begin
        main_valid_d = main_valid;
        main_instr_d = main_instr;
        main_pc_d    = main_pc;
        skid_valid_d = skid_valid;
        skid_instr_d = skid_instr;
        skid_pc_d    = skid_pc;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_valid && !out_ready) begin
            if (accept) begin
                skid_valid_d = 1'b1;
                skid_instr_d = in_instr;
                skid_pc_d    = in_pc;
            end
        end else if (skid_valid) begin
            // older skid entry goes first to keep program order
            main_valid_d = 1'b1;
            main_instr_d = skid_instr;
            main_pc_d    = skid_pc;
            skid_valid_d = accept;
            if (accept) begin
                skid_instr_d = in_instr;
                skid_pc_d    = in_pc;
            end
        end else begin
            main_valid_d = accept;
            if (accept) begin
                main_instr_d = in_instr;
                main_pc_d    = in_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_instr <= '0;
            main_pc    <= '0;
            skid_valid <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
            in_ready   <= 1'b0;
        end else begin
            main_valid <= main_valid_d;
            main_instr <= main_instr_d;
            main_pc    <= main_pc_d;
            skid_valid <= skid_valid_d;
            skid_instr <= skid_instr_d;
            skid_pc    <= skid_pc_d;
            in_ready   <= ~skid_valid_d;
        end
    end

    assign out_valid  = main_valid;
    assign out_pc     = main_pc;
    assign out_opcode = main_instr[31:26];
    assign out_rs     = main_instr[25:21];
    assign out_rt     = main_instr[20:16];
    assign out_rd     = main_instr[15:11];
    assign out_shamt  = main_instr[10:6];
    assign out_funct  = main_instr[5:0];
    assign out_imm16  = main_instr[IMM_W-1:0];
    assign out_target = {main_instr[25:0], 2'b00};
    assign out_class  = classify(main_instr[31:26]);

    signExtend #(
        .IN_W  (IMM_W),
        .OUT_W (WORD_W)
    ) u_sign_extend (
        .immediate (main_instr[IMM_W-1:0]),
        .extended  (imm_sext)
    );

    always_comb begin
        out_imm_ext = imm_sext;
        case (main_instr[31:26])
            OP_ANDI, OP_ORI, OP_XORI: out_imm_ext = {{(WORD_W-IMM_W){1'b0}}, main_instr[IMM_W-1:0]};
            OP_LUI:                   out_imm_ext = {main_instr[IMM_W-1:0], {(WORD_W-IMM_W){1'b0}}};
            default:                  out_imm_ext = imm_sext;
        endcase
    end

endmodule

// File: tb/tb_if_id_decode.sv
// Directed bench for if_id_decode: decode vector table plus backpressure,
// flush and mid-cycle reset sequences.
module tb_if_id_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [5:0]  out_opcode;
    logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
    logic [5:0]  out_funct;
    logic [15:0] out_imm16;
    logic [31:0] out_imm_ext;
    logic [27:0] out_target;
    logic [1:0]  out_class;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    if_id_decode #(.WORD_W(32), .IMM_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_shamt(out_shamt), .out_funct(out_funct), .out_imm16(out_imm16),
        .out_imm_ext(out_imm_ext), .out_target(out_target), .out_class(out_class)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd, shamt;
        logic [5:0]  funct;
        logic [31:0] imm_ext;
        logic [27:0] target;
        logic [1:0]  cls;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        //          instr         pc           op     rs  rt  rd     sh  funct  imm_ext       target        cls
        vecs[0] = '{32'h2008FFFE, 32'h100, 6'h08, 5'd0,  5'd8, 5'd31, 5'd31, 6'h3E, 32'hFFFFFFFE, 28'h0023FFF8, 2'd1};
        vecs[1] = '{32'h3508F0F0, 32'h104, 6'h0D, 5'd8,  5'd8, 5'd30, 5'd3,  6'h30, 32'h0000F0F0, 28'h0423C3C0, 2'd1};
        vecs[2] = '{32'h3C081234, 32'h108, 6'h0F, 5'd0,  5'd8, 5'd2,  5'd8,  6'h34, 32'h12340000, 28'h002048D0, 2'd1};
        vecs[3] = '{32'h08000010, 32'h10C, 6'h02, 5'd0,  5'd0, 5'd0,  5'd0,  6'h10, 32'h00000010, 28'h0000040,  2'd2};
        vecs[4] = '{32'h46000000, 32'h110, 6'h11, 5'd16, 5'd0, 5'd0,  5'd0,  6'h00, 32'h00000000, 28'h8000000,  2'd3};
        vecs[5] = '{32'h01095020, 32'h114, 6'h00, 5'd8,  5'd9, 5'd10, 5'd0,  6'h20, 32'h00005020, 28'h4254080,  2'd0};
        vecs[6] = '{32'h31088000, 32'h118, 6'h0C, 5'd8,  5'd8, 5'd16, 5'd0,  6'h00, 32'h00008000, 28'h4220000,  2'd1};

        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
        #12;
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset out_class", {30'b0, out_class}, 32'd0);
        check("reset out_pc", out_pc, 32'd0);
        check("reset out_imm_ext", out_imm_ext, 32'd0);
        rst_n = 1'b1;
        step();
        check("in_ready after reset", {31'b0, in_ready}, 32'd1);

        for (int i = 0; i < 7; i++) begin
            send(vecs[i].instr, vecs[i].pc);
            check($sformatf("v%0d out_valid", i), {31'b0, out_valid}, 32'd1);
            check($sformatf("v%0d out_pc", i), out_pc, vecs[i].pc);
            check($sformatf("v%0d opcode", i), {26'b0, out_opcode}, {26'b0, vecs[i].op});
            check($sformatf("v%0d rs", i), {27'b0, out_rs}, {27'b0, vecs[i].rs});
            check($sformatf("v%0d rt", i), {27'b0, out_rt}, {27'b0, vecs[i].rt});
            check($sformatf("v%0d rd", i), {27'b0, out_rd}, {27'b0, vecs[i].rd});
            check($sformatf("v%0d shamt", i), {27'b0, out_shamt}, {27'b0, vecs[i].shamt});
            check($sformatf("v%0d funct", i), {26'b0, out_funct}, {26'b0, vecs[i].funct});
            check($sformatf("v%0d imm16", i), {16'b0, out_imm16}, {16'b0, vecs[i].instr[15:0]});
            check($sformatf("v%0d imm_ext", i), out_imm_ext, vecs[i].imm_ext);
            check($sformatf("v%0d target", i), {4'b0, out_target}, {4'b0, vecs[i].target});
            check($sformatf("v%0d class", i), {30'b0, out_class}, {30'b0, vecs[i].cls});
            step();
            check($sformatf("v%0d drained", i), {31'b0, out_valid}, 32'd0);
        end

        // backpressure: A, B buffered, C held off, then all three drain in order
        out_ready = 1'b0;
        send(32'h2008FFFE, 32'hA00);
        check("bp A on out", out_pc, 32'hA00);
        check("bp in_ready after A", {31'b0, in_ready}, 32'd1);
        send(32'h3508F0F0, 32'hB00);
        check("bp in_ready after B", {31'b0, in_ready}, 32'd0);
        check("bp A stable pc", out_pc, 32'hA00);
        in_valid = 1'b1; in_instr = 32'h3C081234; in_pc = 32'hC00;
        step(); step();
        check("bp C held in_ready", {31'b0, in_ready}, 32'd0);
        check("bp A stable rt", {27'b0, out_rt}, 32'd8);
        check("bp A stable imm", out_imm_ext, 32'hFFFFFFFE);
        out_ready = 1'b1;
        #1;
        check("bp exit A", out_pc, 32'hA00);
        step();
        check("bp exit B", out_pc, 32'hB00);
        check("bp exit B valid", {31'b0, out_valid}, 32'd1);
        check("bp in_ready after skid drain", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check("bp exit C", out_pc, 32'hC00);
        check("bp exit C imm", out_imm_ext, 32'h12340000);
        step();
        check("bp empty", {31'b0, out_valid}, 32'd0);

        // flush with skid full and a same-cycle input
        out_ready = 1'b0;
        send(32'h2008FFFE, 32'hA10);
        send(32'h3508F0F0, 32'hB10);
        check("fl skid full", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b1; in_instr = 32'h3C081234; in_pc = 32'hC10; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("fl out_valid", {31'b0, out_valid}, 32'd0);
        check("fl in_ready", {31'b0, in_ready}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("fl C absent %0d", k), {31'b0, out_valid}, 32'd0);
        end

        // asynchronous reset mid-cycle with two entries held
        out_ready = 1'b0;
        send(32'h2008FFFE, 32'hA20);
        send(32'h3508F0F0, 32'hB20);
        check("rst two held", {31'b0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst async out_valid", {31'b0, out_valid}, 32'd0);
        check("rst async out_pc", out_pc, 32'd0);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        check("rst release in_ready", {31'b0, in_ready}, 32'd1);
        check("rst release out_valid", {31'b0, out_valid}, 32'd0);
        step();
        check("rst entries gone", {31'b0, out_valid}, 32'd0);

        // accept after reset still has latency 1
        send(32'h08000010, 32'hD00);
        check("post rst class", {30'b0, out_class}, 32'd2);
        check("post rst pc", out_pc, 32'hD00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
